// File: rtl/dff_en_reg_pkg.sv
// Shared constants for the enable-register slice.
`timescale 1ps/1ps
package dff_en_reg_pkg;
   localparam int unsigned DEFAULT_WIDTH = 1;
   localparam int unsigned CLOCK_PERIOD  = 200;
endpackage

// File: rtl/D_FF.sv
// Codebase primitive: plain rising-edge D flip-flop, no reset.
`timescale 1ps/1ps
module D_FF (
   output logic q,
   input  logic d,
   input  logic clk
);
   always_ff @(posedge clk) begin
      q <= d;
   end
endmodule

// File: rtl/dff_en_reg_bit.sv
// One enable-flop cell: hold/load mux, then reset-value injection, then a plain flop.
`timescale 1ps/1ps
module dff_en_bit
   import dff_en_reg_pkg::*;
#(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic wren,
   input  logic d,
   output logic q
);
   logic next;
   logic flop_in;

   mux2_1 u_mux (
      .out (next),
      .i0  (q),
      .i1  (d),
      .sel (wren)
   );

   // Synchronous reset is realised by forcing the flop input, so it overrides wren.
   always_comb begin
      flop_in = reset ? next : RESET_BIT;
   end

   D_FF u_ff (
      .q   (q),
      .d   (flop_in),
      .clk (clk)
   );
endmodule

// File: rtl/mux2_1.sv
// Codebase primitive: 2:1 multiplexer, sel=1 picks i1.
`timescale 1ps/1ps
module mux2_1 (
   output logic out,
   input  logic i0,
   input  logic i1,
   input  logic sel
);
   always_comb begin
      out = sel ? i1 : i0;
   end
endmodule

// File: rtl/dff_en_reg.sv
// WIDTH-bit write-enabled register built from a row of dff_en_bit cells.
`timescale 1ps/1ps
module dff_en_reg
   import dff_en_reg_pkg::*;
#(
   parameter int unsigned       WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wren,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_en_bit #(
         .RESET_BIT (RESET_VALUE[i])
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .wren  (wren),
         .d     (D[i]),
         .q     (Q[i])
      );
   end
endmodule

// File: tb/tb_dff_en_reg.sv
// Directed bench: 1-bit default instance and an 8-bit instance with RESET_VALUE 8'hA5.
`timescale 1ps/1ps
module tb_dff_en_reg;
   import dff_en_reg_pkg::*;

   logic       clk = 1'b0;
   logic       reset1 = 1'b0, wren1 = 1'b0;
   logic [0:0] d1 = '0;
   logic [0:0] q1;
   logic       reset8 = 1'b0, wren8 = 1'b0;
   logic [7:0] d8 = '0;
   logic [7:0] q8;
   int         tests = 0;
   int         failures = 0;

   always #(CLOCK_PERIOD/2) clk = ~clk;

   dff_en_reg u_w1 (
      .clk   (clk),
      .reset (reset1),
      .wren  (wren1),
      .D     (d1),
      .Q     (q1)
   );

   dff_en_reg #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_w8 (
      .clk   (clk),
      .reset (reset8),
      .wren  (wren8),
      .D     (d8),
      .Q     (q8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with all-ones data
      reset1 = 1'b0; wren1 = 1'b0; d1 = 1'b1;
      step();
      check("reset", {7'b0, q1}, 8'h00);

      // Hold after reset
      reset1 = 1'b1; wren1 = 1'b0; d1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_zero", {7'b0, q1}, 8'h00);
      end

      // Write then keep writing
      wren1 = 1'b1; d1 = 1'b1;
      step();
      check("write_first", {7'b0, q1}, 8'h01);
      for (int i = 0; i < 4; i++) begin
         step();
         check("write_cont", {7'b0, q1}, 8'h01);
      end

      // Hold with toggling data
      wren1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d1 = (i % 2 == 0) ? 1'b0 : 1'b1;
         step();
         check("hold_toggle", {7'b0, q1}, 8'h01);
      end

      // Glitch on wren/D between edges, low again before the edge
      d1 = 1'b0;
      #50 wren1 = 1'b1;
      #20 wren1 = 1'b0;
      step();
      check("glitch", {7'b0, q1}, 8'h01);

      // Reset beats write
      reset1 = 1'b0; wren1 = 1'b1; d1 = 1'b1;
      step();
      check("reset_prio", {7'b0, q1}, 8'h00);
      reset1 = 1'b1;
      step();
      check("post_reset_wr", {7'b0, q1}, 8'h01);

      // Multi-bit: reset value, write, hold
      reset8 = 1'b0; wren8 = 1'b1; d8 = 8'hFF;
      step();
      check("w8_reset", q8, 8'hA5);
      reset8 = 1'b1; wren8 = 1'b0; d8 = 8'h5A;
      step();
      check("w8_hold_rst", q8, 8'hA5);
      wren8 = 1'b1; d8 = 8'h3C;
      step();
      check("w8_write", q8, 8'h3C);
      wren8 = 1'b0; d8 = 8'hFF;
      step();
      check("w8_hold1", q8, 8'h3C);
      step();
      check("w8_hold2", q8, 8'h3C);
      wren8 = 1'b1; d8 = 8'h00;
      step();
      check("w8_write0", q8, 8'h00);
      reset8 = 1'b0; d8 = 8'h81;
      step();
      check("w8_reset2", q8, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
